// File: rtl/arb_pkg.sv
// Shared definitions for the arbiter requester: channel state encoding and
// default timing parameters also used by the arbiter bench.
package arb_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        OWN  = 2'd2,
        BACK = 2'd3
    } chan_state_e;

    localparam int DEF_CNT_W     = 4;
    localparam int DEF_BURST_LEN = 4;
    localparam int DEF_TIMEOUT   = 15;
    localparam int DEF_BACKOFF   = 3;

endpackage

// File: rtl/arb_req_chan.sv
// One requester channel: pending-work counter, request/own/backoff FSM and
// sticky overflow flag. req/busy decode from state; done/tmo are registered.
module arb_req_chan
    import arb_pkg::*;
#(
    parameter int CNT_W     = DEF_CNT_W,
    parameter int BURST_LEN = DEF_BURST_LEN,
    parameter int TIMEOUT   = DEF_TIMEOUT,
    parameter int BACKOFF   = DEF_BACKOFF
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             i_push,
    input  logic             i_gnt,
    output logic             o_req,
    output logic             o_busy,
    output logic             o_done,
    output logic             o_tmo,
    output logic             o_ovf,
    output logic [CNT_W-1:0] o_pend
);

    localparam int WAIT_W  = (TIMEOUT   > 1) ? $clog2(TIMEOUT)   : 1;
    localparam int BURST_W = (BURST_LEN > 1) ? $clog2(BURST_LEN) : 1;
    localparam int BACK_W  = (BACKOFF   > 1) ? $clog2(BACKOFF)   : 1;
    localparam logic [CNT_W-1:0] PEND_MAX = {CNT_W{1'b1}};

    chan_state_e        r_state, w_state_nxt;
    logic [WAIT_W-1:0]  r_wait,  w_wait_nxt;
    logic [BURST_W-1:0] r_burst, w_burst_nxt;
    logic [BACK_W-1:0]  r_back,  w_back_nxt;
    logic [CNT_W-1:0]   r_pend,  w_pend_nxt;
    logic               r_ovf,   w_ovf_set;
    logic               r_done,  r_tmo;
    logic               w_complete, w_timeout;

    always_comb begin
        w_state_nxt = r_state;
        w_wait_nxt  = r_wait;
        w_burst_nxt = r_burst;
        w_back_nxt  = r_back;
        w_complete  = 1'b0;
        w_timeout   = 1'b0;
        case (r_state)
            IDLE: begin
                if (r_pend != '0) begin
                    w_state_nxt = REQ;
                    w_wait_nxt  = '0;
                end
            end
            REQ: begin
                if (i_gnt) begin
                    w_state_nxt = OWN;
                    w_burst_nxt = BURST_W'(BURST_LEN - 1);
                end else if (r_wait == WAIT_W'(TIMEOUT - 1)) begin
                    w_state_nxt = BACK;
                    w_back_nxt  = BACK_W'(BACKOFF - 1);
                    w_timeout   = 1'b1;
                end else begin
                    w_wait_nxt = r_wait + 1'b1;
                end
            end
            OWN: begin
                // Losing the grant mid-burst abandons the burst but keeps the work.
                if (!i_gnt) begin
                    w_state_nxt = REQ;
                    w_wait_nxt  = '0;
                end else if (r_burst == '0) begin
                    w_state_nxt = IDLE;
                    w_complete  = 1'b1;
                end else begin
                    w_burst_nxt = r_burst - 1'b1;
                end
            end
            BACK: begin
                // Leave as the count reaches zero; the IDLE cycle ends the quiet period.
                if (r_back <= BACK_W'(1)) begin
                    w_state_nxt = IDLE;
                end else begin
                    w_back_nxt = r_back - 1'b1;
                end
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    always_comb begin
        w_pend_nxt = r_pend;
        w_ovf_set  = 1'b0;
        if (i_push && !w_complete) begin
            if (r_pend == PEND_MAX) begin
                w_ovf_set = 1'b1;
            end else begin
                w_pend_nxt = r_pend + 1'b1;
            end
        end else if (!i_push && w_complete) begin
            w_pend_nxt = r_pend - 1'b1;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            r_state <= IDLE;
            r_wait  <= '0;
            r_burst <= '0;
            r_back  <= '0;
            r_pend  <= '0;
            r_ovf   <= 1'b0;
            r_done  <= 1'b0;
            r_tmo   <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_wait  <= w_wait_nxt;
            r_burst <= w_burst_nxt;
            r_back  <= w_back_nxt;
            r_pend  <= w_pend_nxt;
            r_ovf   <= r_ovf | w_ovf_set;
            r_done  <= w_complete;
            r_tmo   <= w_timeout;
        end
    end

    assign o_req  = (r_state == REQ) || (r_state == OWN);
    assign o_busy = (r_state == OWN);
    assign o_done = r_done;
    assign o_tmo  = r_tmo;
    assign o_ovf  = r_ovf;
    assign o_pend = r_pend;

endmodule

// File: rtl/arb_requester.sv
// Two independent requester channels sitting in front of the arbiter's
// req/gnt pins; bit i of every vector belongs to channel i.
module arb_requester
    import arb_pkg::*;
#(
    parameter int CNT_W     = DEF_CNT_W,
    parameter int BURST_LEN = DEF_BURST_LEN,
    parameter int TIMEOUT   = DEF_TIMEOUT,
    parameter int BACKOFF   = DEF_BACKOFF
) (
    input  logic             clock,
    input  logic             reset,
    input  logic [1:0]       push,
    input  logic [1:0]       gnt,
    output logic [1:0]       req,
    output logic [1:0]       busy,
    output logic [1:0]       done,
    output logic [1:0]       tmo,
    output logic [1:0]       ovf,
    output logic [CNT_W-1:0] pend0,
    output logic [CNT_W-1:0] pend1
);

    logic [CNT_W-1:0] w_pend [2];

    for (genvar g = 0; g < 2; g++) begin : g_chan
        arb_req_chan #(
            .CNT_W     (CNT_W),
            .BURST_LEN (BURST_LEN),
            .TIMEOUT   (TIMEOUT),
            .BACKOFF   (BACKOFF)
        ) u_chan (
            .clock  (clock),
            .reset  (reset),
            .i_push (push[g]),
            .i_gnt  (gnt[g]),
            .o_req  (req[g]),
            .o_busy (busy[g]),
            .o_done (done[g]),
            .o_tmo  (tmo[g]),
            .o_ovf  (ovf[g]),
            .o_pend (w_pend[g])
        );
    end

    assign pend0 = w_pend[0];
    assign pend1 = w_pend[1];

endmodule

// File: tb/tb_arb_requester.sv
// Bench for arb_requester: directed scenarios with fixed expectations plus
// randomized traffic compared every cycle against a transaction-level model.
module tb_arb_requester;

    localparam int BURST_LEN = 4;
    localparam int TIMEOUT   = 15;
    localparam int BACKOFF   = 3;
    localparam int PEND_MAX  = 15;

    logic       clock = 1'b0;
    logic       reset;
    logic [1:0] push, gnt;
    logic [1:0] req, busy, done, tmo, ovf;
    logic [3:0] pend0, pend1;

    int n_checks = 0;
    int n_pass   = 0;

    // Model: requesting flag, owned-cycle count, waited-cycle count, quiet cycles left.
    bit m_active [2];
    int m_owned  [2];
    int m_waited [2];
    int m_quiet  [2];
    int m_pend   [2];
    bit m_ovf    [2];
    bit m_done   [2];
    bit m_tmo    [2];

    always #5 clock = ~clock;

    arb_requester dut (
        .clock (clock),
        .reset (reset),
        .push  (push),
        .gnt   (gnt),
        .req   (req),
        .busy  (busy),
        .done  (done),
        .tmo   (tmo),
        .ovf   (ovf),
        .pend0 (pend0),
        .pend1 (pend1)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
        end else begin
            n_pass++;
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 2; i++) begin
            m_active[i] = 0; m_owned[i] = 0; m_waited[i] = 0; m_quiet[i] = 0;
            m_pend[i] = 0;   m_ovf[i] = 0;   m_done[i] = 0;   m_tmo[i] = 0;
        end
    endtask

    task automatic model_step(input logic r, input logic [1:0] p, input logic [1:0] g);
        bit completion;
        if (r) begin
            model_reset();
            return;
        end
        for (int i = 0; i < 2; i++) begin
            completion = 0;
            m_done[i]  = 0;
            m_tmo[i]   = 0;
            if (!m_active[i]) begin
                if (m_quiet[i] > 1) begin
                    m_quiet[i]--;
                end else begin
                    m_quiet[i] = 0;
                    if (m_pend[i] != 0) begin
                        m_active[i] = 1;
                        m_waited[i] = 0;
                    end
                end
            end else if (m_owned[i] > 0) begin
                if (!g[i]) begin
                    m_owned[i]  = 0;
                    m_waited[i] = 0;
                end else if (m_owned[i] == BURST_LEN) begin
                    m_owned[i]  = 0;
                    m_active[i] = 0;
                    m_done[i]   = 1;
                    completion  = 1;
                end else begin
                    m_owned[i]++;
                end
            end else begin
                if (g[i]) begin
                    m_owned[i] = 1;
                end else if (m_waited[i] == TIMEOUT - 1) begin
                    m_active[i] = 0;
                    m_tmo[i]    = 1;
                    m_quiet[i]  = BACKOFF;
                end else begin
                    m_waited[i]++;
                end
            end
            if (p[i] && !completion) begin
                if (m_pend[i] == PEND_MAX) m_ovf[i] = 1;
                else m_pend[i]++;
            end else if (!p[i] && completion) begin
                m_pend[i]--;
            end
        end
    endtask

    task automatic check_model();
        logic [1:0] e_req, e_busy, e_done, e_tmo, e_ovf;
        for (int i = 0; i < 2; i++) begin
            e_req[i]  = m_active[i];
            e_busy[i] = (m_owned[i] > 0);
            e_done[i] = m_done[i];
            e_tmo[i]  = m_tmo[i];
            e_ovf[i]  = m_ovf[i];
        end
        check("req",   32'(req),   32'(e_req));
        check("busy",  32'(busy),  32'(e_busy));
        check("done",  32'(done),  32'(e_done));
        check("tmo",   32'(tmo),   32'(e_tmo));
        check("ovf",   32'(ovf),   32'(e_ovf));
        check("pend0", 32'(pend0), m_pend[0]);
        check("pend1", 32'(pend1), m_pend[1]);
    endtask

    // One clock: compare against the model, drive inputs, let the edge happen.
    task automatic tick(input logic r, input logic [1:0] p, input logic [1:0] g);
        @(negedge clock);
        check_model();
        reset = r;
        push  = p;
        gnt   = g;
        @(posedge clock);
        model_step(r, p, g);
    endtask

    initial begin
        int c;
        bit seen;
        logic [1:0] rg;

        reset = 1'b1;
        push  = 2'b00;
        gnt   = 2'b00;
        repeat (3) @(posedge clock);
        model_reset();
        #1;
        check("rst_req",  32'(req),   0);
        check("rst_busy", 32'(busy),  0);
        check("rst_flag", 32'({done, tmo, ovf}), 0);
        check("rst_pend", 32'({pend1, pend0}), 0);

        // Single transaction with grant held from cycle 2.
        for (int k = 0; k <= 8; k++) begin
            tick(1'b0, (k == 0) ? 2'b01 : 2'b00, (k >= 2) ? 2'b01 : 2'b00);
            #1; c = k + 1;
            check("t1_req0",  32'(req[0]),  32'(c >= 2 && c <= 6));
            check("t1_busy0", 32'(busy[0]), 32'(c >= 3 && c <= 6));
            check("t1_done0", 32'(done[0]), 32'(c == 7));
            check("t1_pend0", 32'(pend0),   32'(c >= 1 && c <= 6));
        end
        tick(1'b1, 2'b00, 2'b00);

        // Timeout on ch1, backoff, then re-request.
        for (int k = 0; k <= 22; k++) begin
            tick(1'b0, (k == 0) ? 2'b10 : 2'b00, 2'b00);
            #1; c = k + 1;
            check("t2_req1",  32'(req[1]), 32'((c >= 2 && c <= 16) || c >= 20));
            check("t2_tmo1",  32'(tmo[1]), 32'(c == 17));
            check("t2_pend1", 32'(pend1),  1);
        end
        tick(1'b1, 2'b00, 2'b00);

        // Grant dropped after two owned cycles, then regranted for a full burst.
        for (int k = 0; k <= 11; k++) begin
            tick(1'b0, (k == 0) ? 2'b01 : 2'b00, (k == 2 || k == 3 || k >= 6) ? 2'b01 : 2'b00);
            #1; c = k + 1;
            check("t3_busy0", 32'(busy[0]), 32'(c == 3 || c == 4 || (c >= 7 && c <= 10)));
            check("t3_req0",  32'(req[0]),  32'(c >= 2 && c <= 10));
            check("t3_done0", 32'(done[0]), 32'(c == 11));
            check("t3_pend0", 32'(pend0),   32'(c >= 1 && c <= 10));
        end
        tick(1'b1, 2'b00, 2'b00);

        // Push coinciding with the last owned cycle at pend0=2.
        for (int k = 0; k <= 7; k++) begin
            tick(1'b0, (k <= 1 || k == 6) ? 2'b01 : 2'b00, (k >= 2) ? 2'b01 : 2'b00);
            #1; c = k + 1;
            check("t5_pend0", 32'(pend0),   (c == 1) ? 1 : 2);
            check("t5_done0", 32'(done[0]), 32'(c == 7));
            check("t5_req0",  32'(req[0]),  32'((c >= 2 && c <= 6) || c == 8));
        end
        tick(1'b1, 2'b00, 2'b00);

        // Saturation: 17 back-to-back pushes with no grant.
        for (int k = 0; k <= 16; k++) begin
            tick(1'b0, 2'b01, 2'b00);
            #1; c = k + 1;
            check("t4_pend0", 32'(pend0),  (c > PEND_MAX) ? PEND_MAX : c);
            check("t4_ovf0",  32'(ovf[0]), 32'(c >= 16));
        end
        check("t4_ovf1", 32'(ovf[1]), 0);

        // Reset while both channels own the grant.
        seen = 0;
        for (int k = 0; k < 40 && !seen; k++) begin
            tick(1'b0, (k == 0) ? 2'b10 : 2'b00, 2'b11);
            #1;
            if (busy == 2'b11) seen = 1;
        end
        check("t6_both_own", 32'(seen), 1);
        tick(1'b1, 2'b00, 2'b11);
        #1;
        check("t6_req",  32'(req),  0);
        check("t6_busy", 32'(busy), 0);
        check("t6_ovf",  32'(ovf),  0);
        check("t6_pend", 32'({pend1, pend0}), 0);

        // Random traffic with sticky grants and occasional reset.
        tick(1'b0, 2'b00, 2'b00);
        rg = 2'b00;
        for (int k = 0; k < 3000; k++) begin
            logic [1:0] rp;
            for (int i = 0; i < 2; i++) begin
                rp[i] = ($urandom_range(0, 3) == 0);
                if ($urandom_range(0, 5) == 0) rg[i] = ~rg[i];
            end
            tick(($urandom_range(0, 299) == 0), rp, rg);
        end
        tick(1'b0, 2'b00, 2'b00);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
